uart_prog_loader: RTL and testbench

Sequences in-system program loading for the CPU. Consumes the byte stream from the UART receiver and frames it into 24-bit words. It detects start and stop marker words, writes data words into instruction memory at consecutive addresses, and holds the CPU in reset or stall while loading. It sits between the UART receiver and the instruction-memory write port / CPU reset tree in `full_cpu`.

---
 rtl/uart_prog_loader.sv | 155 +++++++++++++++
 tb/tb_uart_prog_loader.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// Frames the UART byte stream into 24-bit words, writes program words into instruction memory
// and holds/resets the CPU around the load. Optional inter-byte timeout: LOADER_TIMEOUT_EN.
module uart_prog_loader #(
    parameter int ADDR_W         = 8,
    parameter int RST_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [23:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              cpu_rst,
    output logic [ADDR_W:0]   word_count,
    output logic              load_err
);

    localparam logic [23:0] START_WORD    = 24'h0000FF;
    localparam logic [23:0] STOP_RST_WORD = 24'h000FFF;
    localparam logic [23:0] STOP_WORD     = 24'h0001FF;

    localparam int                RC_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0]   RC_LAST   = RC_W'(RST_CYCLES - 1);
    localparam logic [ADDR_W:0]   MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] ADDR_TOP  = '1;

`ifdef LOADER_TIMEOUT_EN
    localparam int              TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt;
`endif

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RESET} state_t;

    state_t          state;
    logic [23:0]     window;
    logic [1:0]      idle_cnt;
    logic [1:0]      byte_cnt;
    logic [15:0]     partial;
    logic [RC_W-1:0] rst_cnt;

    logic [23:0] window_next;
    logic [23:0] word_next;

    assign window_next = {window[15:0], rx_data};
    assign word_next   = {partial, rx_data};

    // The write address advances the cycle after the strobe and saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            window     <= '0;
            idle_cnt   <= '0;
            byte_cnt   <= '0;
            partial    <= '0;
            rst_cnt    <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b0;
            cpu_rst    <= 1'b0;
            word_count <= '0;
            load_err   <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            to_cnt     <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            if (imem_we && imem_addr != ADDR_TOP)
                imem_addr <= imem_addr + ADDR_W'(1);

            case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        window <= window_next;
                        if (idle_cnt != 2'd3)
                            idle_cnt <= idle_cnt + 2'd1;
                        if (idle_cnt >= 2'd2 && window_next == START_WORD) begin
                            state      <= S_LOAD;
                            cpu_hold   <= 1'b1;
                            imem_addr  <= '0;
                            byte_cnt   <= '0;
                            partial    <= '0;
                            word_count <= '0;
                            load_err   <= 1'b0;
                        end
                    end
                end

                S_LOAD: begin
`ifdef LOADER_TIMEOUT_EN
                    // A stalled partial word is dropped; the next byte starts a fresh word.
                    if (rx_valid || byte_cnt == 2'd0) begin
                        to_cnt <= '0;
                    end else if (to_cnt == TO_LAST) begin
                        to_cnt   <= '0;
                        byte_cnt <= '0;
                        partial  <= '0;
                        load_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                    if (rx_valid) begin
                        if (byte_cnt == 2'd2) begin
                            byte_cnt <= '0;
                            partial  <= '0;
                            if (word_next == START_WORD) begin
                                imem_addr  <= '0;
                                word_count <= '0;
                                load_err   <= 1'b0;
                            end else if (word_next == STOP_RST_WORD) begin
                                state   <= S_RESET;
                                cpu_rst <= 1'b1;
                                rst_cnt <= RC_LAST;
                            end else if (word_next == STOP_WORD) begin
                                state    <= S_IDLE;
                                cpu_hold <= 1'b0;
                                window   <= '0;
                                idle_cnt <= '0;
                            end else if (word_count == MAX_WORDS) begin
                                load_err <= 1'b1;
                            end else begin
                                imem_we    <= 1'b1;
                                imem_wdata <= word_next;
                                word_count <= word_count + (ADDR_W+1)'(1);
                            end
                        end else begin
                            partial  <= {partial[7:0], rx_data};
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end

                S_RESET: begin
                    if (rst_cnt == '0) begin
                        state    <= S_IDLE;
                        cpu_rst  <= 1'b0;
                        cpu_hold <= 1'b0;
                        window   <= '0;
                        idle_cnt <= '0;
                    end else begin
                        rst_cnt <= rst_cnt - RC_W'(1);
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: directed and randomized byte streams compared
// against a stream-level reference model of the loader protocol.
module tb_uart_prog_loader;

    localparam logic [23:0] START_W    = 24'h0000FF;
    localparam logic [23:0] STOP_RST_W = 24'h000FFF;
    localparam logic [23:0] STOP_W     = 24'h0001FF;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;

    logic        imem_we, cpu_hold, cpu_rst, load_err;
    logic [7:0]  imem_addr;
    logic [23:0] imem_wdata;
    logic [8:0]  word_count;

    logic        imem_we_s, cpu_hold_s, cpu_rst_s, load_err_s;
    logic [1:0]  imem_addr_s;
    logic [23:0] imem_wdata_s;
    logic [2:0]  word_count_s;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  stim[$];
    int          exp_addr[$];
    logic [23:0] exp_data[$];
    int          exp_wc, exp_pulses;
    logic        exp_err, exp_hold;

    int          act_addr[$], act_addr_s[$];
    logic [23:0] act_data[$], act_data_s[$];
    int          rst_cycles;

    uart_prog_loader #(.ADDR_W(8), .RST_CYCLES(16), .TIMEOUT_CYCLES(1000)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .cpu_rst(cpu_rst), .word_count(word_count), .load_err(load_err)
    );

    uart_prog_loader #(.ADDR_W(2), .RST_CYCLES(16), .TIMEOUT_CYCLES(1000)) dut_small (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .imem_we(imem_we_s), .imem_addr(imem_addr_s), .imem_wdata(imem_wdata_s),
        .cpu_hold(cpu_hold_s), .cpu_rst(cpu_rst_s), .word_count(word_count_s),
        .load_err(load_err_s)
    );

    always #5 clk = ~clk;

    // Record every write strobe and every cycle of CPU reset, sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            act_addr.push_back(int'(imem_addr));
            act_data.push_back(imem_wdata);
        end
        if (imem_we_s === 1'b1) begin
            act_addr_s.push_back(int'(imem_addr_s));
            act_data_s.push_back(imem_wdata_s);
        end
        if (cpu_rst === 1'b1)
            rst_cycles++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic apply_stimulus(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = $urandom_range(0, 255);
    endtask

    task automatic push_word(input logic [23:0] w);
        stim.push_back(w[23:16]);
        stim.push_back(w[15:8]);
        stim.push_back(w[7:0]);
    endtask

    task automatic drive_stim(input int max_gap);
        foreach (stim[i]) begin
            apply_stimulus(stim[i]);
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        act_addr.delete(); act_data.delete();
        act_addr_s.delete(); act_data_s.delete();
        rst_cycles = 0;
        stim.delete();
    endtask

    function automatic logic [23:0] rand_data_word();
        logic [23:0] w;
        do w = 24'($urandom);
        while (w == START_W || w == STOP_W || w == STOP_RST_W);
        return w;
    endfunction

    // Protocol-level model: sliding START search in idle, aligned words while loading,
    // address equals the number of words already stored.
    task automatic run_model(input int cap);
        bit          loading = 0;
        int          seen = 0;
        int          n = 0;
        logic [23:0] win = '0;
        logic [23:0] cur = '0;
        exp_addr.delete(); exp_data.delete();
        exp_wc = 0; exp_err = 0; exp_pulses = 0;
        foreach (stim[i]) begin
            if (!loading) begin
                win = {win[15:0], stim[i]};
                seen++;
                if (seen >= 3 && win == START_W) begin
                    loading = 1; exp_wc = 0; exp_err = 0; n = 0;
                end
            end else begin
                cur = {cur[15:0], stim[i]};
                n++;
                if (n == 3) begin
                    n = 0;
                    if (cur == START_W) begin
                        exp_wc = 0; exp_err = 0;
                    end else if (cur == STOP_RST_W || cur == STOP_W) begin
                        loading = 0; seen = 0; win = '0;
                        if (cur == STOP_RST_W) exp_pulses++;
                    end else if (exp_wc == cap) begin
                        exp_err = 1;
                    end else begin
                        exp_addr.push_back(exp_wc);
                        exp_data.push_back(cur);
                        exp_wc++;
                    end
                end
            end
        end
        exp_hold = loading;
    endtask

    task automatic test_reset;
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (imem_we !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_we: got %b expected 0", imem_we); end
        n_cmp++; if (imem_addr !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_addr: got %h expected 00", imem_addr); end
        n_cmp++; if (imem_wdata !== 24'h0) begin n_bad++; $display("[TB] FAIL reset_wdata: got %h expected 000000", imem_wdata); end
        n_cmp++; if (cpu_hold !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_hold: got %b expected 0", cpu_hold); end
        n_cmp++; if (cpu_rst !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_cpu_rst: got %b expected 0", cpu_rst); end
        n_cmp++; if (word_count !== 9'd0) begin n_bad++; $display("[TB] FAIL reset_wc: got %0d expected 0", word_count); end
        n_cmp++; if (load_err !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_err: got %b expected 0", load_err); end
    endtask

    task automatic test_basic;
        do_reset();
        apply_stimulus(8'h00); apply_stimulus(8'h00); apply_stimulus(8'hFF);
        n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("[TB] FAIL start_hold: got %b expected 1", cpu_hold); end
        apply_stimulus(8'hF0); apply_stimulus(8'h00); apply_stimulus(8'h6C);
        n_cmp++;
        if (imem_we !== 1'b1 || imem_addr !== 8'h00 || imem_wdata !== 24'hF0006C) begin
            n_bad++;
            $display("[TB] FAIL write_latency: got we=%b addr=%h data=%h expected we=1 addr=00 data=f0006c",
                     imem_we, imem_addr, imem_wdata);
        end
        @(negedge clk);
        n_cmp++;
        if (imem_we !== 1'b0 || imem_addr !== 8'h01) begin
            n_bad++;
            $display("[TB] FAIL addr_increment: got we=%b addr=%h expected we=0 addr=01", imem_we, imem_addr);
        end
        apply_stimulus(8'hAC); apply_stimulus(8'hF2); apply_stimulus(8'h8F);
        apply_stimulus(8'h00); apply_stimulus(8'h0F); apply_stimulus(8'hFF);
        n_cmp++;
        if (cpu_rst !== 1'b1 || cpu_hold !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL stop_rst_entry: got rst=%b hold=%b expected rst=1 hold=1", cpu_rst, cpu_hold);
        end
        repeat (25) @(negedge clk);
        push_word(START_W); push_word(24'hF0006C); push_word(24'hACF28F); push_word(STOP_RST_W);
        run_model(256);
        n_cmp++; if (act_addr.size() != exp_addr.size()) begin n_bad++; $display("[TB] FAIL basic_nwrites: got %0d expected %0d", act_addr.size(), exp_addr.size()); end
        for (int i = 0; i < act_addr.size() && i < exp_addr.size(); i++) begin
            n_cmp++;
            if (act_addr[i] != exp_addr[i] || act_data[i] !== exp_data[i]) begin
                n_bad++;
                $display("[TB] FAIL basic_write%0d: got %0d<-%h expected %0d<-%h", i, act_addr[i], act_data[i], exp_addr[i], exp_data[i]);
            end
        end
        n_cmp++; if (word_count !== 9'(exp_wc)) begin n_bad++; $display("[TB] FAIL basic_wc: got %0d expected %0d", word_count, exp_wc); end
        n_cmp++; if (rst_cycles != 16 * exp_pulses) begin n_bad++; $display("[TB] FAIL basic_rst_len: got %0d expected %0d", rst_cycles, 16 * exp_pulses); end
        n_cmp++; if (cpu_hold !== 1'b0) begin n_bad++; $display("[TB] FAIL basic_hold_after: got %b expected 0", cpu_hold); end
    endtask

    task automatic test_garbage;
        do_reset();
        stim.push_back(8'h12); stim.push_back(8'h34);
        push_word(START_W); push_word(24'h112233); push_word(STOP_W);
        drive_stim(0);
        n_cmp++; if (cpu_hold !== 1'b0) begin n_bad++; $display("[TB] FAIL stop_hold: got %b expected 0", cpu_hold); end
        repeat (5) @(negedge clk);
        run_model(256);
        n_cmp++; if (act_addr.size() != exp_addr.size()) begin n_bad++; $display("[TB] FAIL garbage_nwrites: got %0d expected %0d", act_addr.size(), exp_addr.size()); end
        for (int i = 0; i < act_addr.size() && i < exp_addr.size(); i++) begin
            n_cmp++;
            if (act_addr[i] != exp_addr[i] || act_data[i] !== exp_data[i]) begin
                n_bad++;
                $display("[TB] FAIL garbage_write%0d: got %0d<-%h expected %0d<-%h", i, act_addr[i], act_data[i], exp_addr[i], exp_data[i]);
            end
        end
        n_cmp++; if (rst_cycles != 0) begin n_bad++; $display("[TB] FAIL garbage_no_cpu_rst: got %0d expected 0", rst_cycles); end
    endtask

    task automatic test_restart;
        do_reset();
        push_word(START_W); push_word(24'h0A0B0C); push_word(START_W);
        push_word(24'h0D0E0F); push_word(STOP_W);
        // Misaligned restart: a START split across words, realigned by a later aligned START.
        push_word(START_W); stim.push_back(8'h01); stim.push_back(8'h02);
        push_word(START_W); push_word(24'h0A0B0C); push_word(STOP_W);
        stim.push_back(8'h00);
        push_word(START_W); push_word(24'h0A0B0C); push_word(STOP_W);
        drive_stim(2);
        repeat (5) @(negedge clk);
        run_model(256);
        n_cmp++; if (act_addr.size() != exp_addr.size()) begin n_bad++; $display("[TB] FAIL restart_nwrites: got %0d expected %0d", act_addr.size(), exp_addr.size()); end
        for (int i = 0; i < act_addr.size() && i < exp_addr.size(); i++) begin
            n_cmp++;
            if (act_addr[i] != exp_addr[i] || act_data[i] !== exp_data[i]) begin
                n_bad++;
                $display("[TB] FAIL restart_write%0d: got %0d<-%h expected %0d<-%h", i, act_addr[i], act_data[i], exp_addr[i], exp_data[i]);
            end
        end
        n_cmp++; if (word_count !== 9'(exp_wc)) begin n_bad++; $display("[TB] FAIL restart_wc: got %0d expected %0d", word_count, exp_wc); end
        n_cmp++; if (cpu_hold !== exp_hold) begin n_bad++; $display("[TB] FAIL restart_hold: got %b expected %b", cpu_hold, exp_hold); end
    endtask

    task automatic test_overflow;
        do_reset();
        push_word(START_W);
        for (int i = 0; i < 5; i++) push_word(rand_data_word());
        push_word(STOP_W);
        drive_stim(1);
        repeat (5) @(negedge clk);
        run_model(4);
        n_cmp++; if (act_addr_s.size() != exp_addr.size()) begin n_bad++; $display("[TB] FAIL ovf_nwrites: got %0d expected %0d", act_addr_s.size(), exp_addr.size()); end
        for (int i = 0; i < act_addr_s.size() && i < exp_addr.size(); i++) begin
            n_cmp++;
            if (act_addr_s[i] != exp_addr[i] || act_data_s[i] !== exp_data[i]) begin
                n_bad++;
                $display("[TB] FAIL ovf_write%0d: got %0d<-%h expected %0d<-%h", i, act_addr_s[i], act_data_s[i], exp_addr[i], exp_data[i]);
            end
        end
        n_cmp++; if (load_err_s !== exp_err) begin n_bad++; $display("[TB] FAIL ovf_err: got %b expected %b", load_err_s, exp_err); end
        n_cmp++; if (word_count_s !== 3'(exp_wc)) begin n_bad++; $display("[TB] FAIL ovf_wc: got %0d expected %0d", word_count_s, exp_wc); end
    endtask

    task automatic test_back_to_back;
        for (int it = 0; it < 6; it++) begin
            do_reset();
            repeat ($urandom_range(0, 3)) stim.push_back(8'($urandom_range(1, 254)));
            push_word(START_W);
            repeat ($urandom_range(1, 8)) push_word(rand_data_word());
            push_word(($urandom_range(0, 1) == 1) ? STOP_RST_W : STOP_W);
            drive_stim((it < 3) ? 0 : 2);
            repeat (25) @(negedge clk);
            run_model(256);
            n_cmp++; if (act_addr.size() != exp_addr.size()) begin n_bad++; $display("[TB] FAIL rand%0d_nwrites: got %0d expected %0d", it, act_addr.size(), exp_addr.size()); end
            for (int i = 0; i < act_addr.size() && i < exp_addr.size(); i++) begin
                n_cmp++;
                if (act_addr[i] != exp_addr[i] || act_data[i] !== exp_data[i]) begin
                    n_bad++;
                    $display("[TB] FAIL rand%0d_write%0d: got %0d<-%h expected %0d<-%h", it, i, act_addr[i], act_data[i], exp_addr[i], exp_data[i]);
                end
            end
            n_cmp++; if (word_count !== 9'(exp_wc)) begin n_bad++; $display("[TB] FAIL rand%0d_wc: got %0d expected %0d", it, word_count, exp_wc); end
            n_cmp++; if (rst_cycles != 16 * exp_pulses) begin n_bad++; $display("[TB] FAIL rand%0d_rst_len: got %0d expected %0d", it, rst_cycles, 16 * exp_pulses); end
            n_cmp++; if (cpu_hold !== exp_hold) begin n_bad++; $display("[TB] FAIL rand%0d_hold: got %b expected %b", it, cpu_hold, exp_hold); end
        end
    endtask

    task automatic test_abort;
        int writes_before;
        do_reset();
        push_word(START_W); push_word(24'h112233);
        stim.push_back(8'hF0); stim.push_back(8'h00);
        drive_stim(0);
        writes_before = act_addr.size();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (imem_we !== 1'b0 || imem_addr !== 8'h00 || imem_wdata !== 24'h0 || cpu_hold !== 1'b0 ||
            cpu_rst !== 1'b0 || word_count !== 9'd0 || load_err !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL abort_outputs: got we=%b addr=%h data=%h hold=%b rst=%b wc=%0d err=%b expected all zero",
                     imem_we, imem_addr, imem_wdata, cpu_hold, cpu_rst, word_count, load_err);
        end
        apply_stimulus(8'h6C);
        repeat (3) @(negedge clk);
        n_cmp++; if (act_addr.size() != writes_before) begin n_bad++; $display("[TB] FAIL abort_no_write: got %0d writes expected %0d", act_addr.size(), writes_before); end
        n_cmp++; if (cpu_hold !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_idle: got hold=%b expected 0", cpu_hold); end
    endtask

`ifdef LOADER_TIMEOUT_EN
    task automatic test_timeout;
        do_reset();
        push_word(START_W);
        drive_stim(0);
        apply_stimulus(8'hAA);
        repeat (1000) @(negedge clk);
        apply_stimulus(8'h01); apply_stimulus(8'h02); apply_stimulus(8'h03);
        apply_stimulus(8'h00); apply_stimulus(8'h01); apply_stimulus(8'hFF);
        repeat (3) @(negedge clk);
        n_cmp++; if (load_err !== 1'b1) begin n_bad++; $display("[TB] FAIL timeout_err: got %b expected 1", load_err); end
        n_cmp++;
        if (act_addr.size() != 1 || act_addr[0] != 0 || act_data[0] !== 24'h010203) begin
            n_bad++;
            $display("[TB] FAIL timeout_write: got %0d writes expected one write 0<-010203", act_addr.size());
        end
    endtask
`endif

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rst_cycles = 0;
        test_reset();
        test_basic();
        test_garbage();
        test_restart();
        test_overflow();
        test_back_to_back();
        test_abort();
`ifdef LOADER_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
